i2c_slave_regfile_block: RTL
============================

# i2c_slave_regfile_block

- I2C target (slave) that sits directly downstream of the I2C master on the shared `sda_io`/`scl_io` bus.
- Decodes START, repeated START and STOP, matches a fixed 7-bit address, and ACKs.
- Writes incoming bytes into an internal register file through an auto-incrementing pointer, and serves reads from it.
- Serves as the bus-side counterpart of the master in directed and system-level tests.
- Oversamples the bus with a single core clock; no clock stretching.

## Interface

Parameters:

- `SLAVE_ADDR`, 7'h50: 7-bit target address.
- `DEPTH`, 16: register-file entries. Power of two, 2..256.

Ports:

- `i2c_core_clock_i`, in, 1: sole clock.
- `reset_bit_n_i`, in, 1: reset, asynchronous, active-low.
- `scl_i`, in, 1: bus SCL, asynchronous to the core clock.
- `sda_i`, in, 1: bus SDA, asynchronous to the core clock.
- `sda_oe_o`, out, 1: 1 = pull SDA low; 0 = release. The top level converts this to open drain.
- `busy_o`, out, 1: 1 from START until STOP.
- `addr_match_o`, out, 1: 1 from the address ACK until STOP or the next START.
- `wr_valid_o`, out, 1: one-cycle pulse per data byte stored.
- `wr_addr_o`, out, log2(DEPTH): register index of the stored byte.
- `wr_data_o`, out, 8: value of the stored byte.

## Operation

Input conditioning:

- `scl_i` and `sda_i` each pass through a 2-flop synchronizer, then one history flop.
- Rise, fall, START and STOP are decoded from the synchronized pair:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- SDA is sampled on each SCL rise. `sda_oe_o` changes only on SCL falls.

State machine:

- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START (including repeated START) from any state: go to ADDR and clear the bit counter. `sda_oe_o` is 0 in the same cycle.
- STOP from any state: go to IDLE, `sda_oe_o` = 0.
- START and STOP take priority over all other transitions.
- ADDR:
  - Shift in 8 bits, MSB first.
  - Bits [7:1] equal `SLAVE_ADDR`: go to ADDR_ACK and latch R/W.
  - Mismatch: go to IDLE and ignore the bus until the next START.
- ACK drive (ADDR_ACK, PTR_ACK, WDATA_ACK):
  - Assert `sda_oe_o` on the SCL fall after bit 8.
  - Release it on the next SCL fall, which ends the 9th clock.
- After ADDR_ACK:
  - W: go to PTR.
  - R: go to RDATA, loading `regs[ptr]` at the ACK-release fall and driving its MSB.
- PTR:
  - The first write byte sets `ptr = byte mod DEPTH`.
  - Go to PTR_ACK, then WDATA.
- WDATA:
  - At the 8th rise: `regs[ptr] <= byte`, pulse `wr_valid_o` with `wr_addr_o = ptr` and `wr_data_o = byte`, then `ptr <= ptr+1 mod DEPTH`.
  - Go to WDATA_ACK, then WDATA.
- RDATA:
  - On each SCL fall, drive `sda_oe_o = ~shift[7]` and shift left.
  - After 8 bits, release SDA and go to RDATA_ACK. `ptr` increments when the byte is loaded.
- RDATA_ACK:
  - Sample master ACK on the SCL rise.
  - ACK (0): load `regs[ptr]` on the next fall and return to RDATA.
  - NACK (1): go to IDLE; SDA stays released.
- `ptr` and `regs` persist across transactions. A read with no preceding pointer write starts at the current `ptr`.
- The slave never ACKs in the 9th clock of a read.

## Timing

- Bus-event detection latency: 3 core cycles after the pin change (2 synchronizer + 1 edge).
- SDA hold requirement: `sda_oe_o` changes 3 cycles after the SCL fall. SCL low time must therefore be at least 6 core cycles, i.e. core clock at least 12× SCL.
- `wr_valid_o` pulses 1 cycle after the detected 8th rise of a data byte.
- Reset values:
  - `sda_oe_o`=0, `busy_o`=0, `addr_match_o`=0, `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0.
  - `ptr`=0, all `regs`=8'h00, state IDLE.
  - Synchronizer flops reset to 1 (idle bus).
- Reset asserted mid-transfer releases SDA immediately (asynchronously). After reset release, the bus is ignored until a fresh START.
- STOP or START mid-byte aborts the byte. No partial write; `ptr` is unchanged.
- Pointer wrap: write at `ptr = DEPTH-1` stores, then wraps to 0. A read wraps the same way.
- SCL rise and STOP/START detected in the same cycle: STOP/START wins.

## Test plan

- Write then read back:
  - Stimulus: START, 0xA0 (0x50 W), 0x03, 0xA5, 0x5A, STOP.
  - Response: ACK on all 4 bytes; `wr_valid_o` pulses with (3, 0xA5) then (4, 0x5A); `regs[3]=0xA5`, `regs[4]=0x5A`.
- Repeated-start read:
  - Stimulus: START, 0xA0, 0x03, rSTART, 0xA1, master ACK, master NACK, STOP.
  - Response: SDA returns 0xA5 then 0x5A; no `wr_valid_o`; `ptr` = 5 afterwards.
- Address mismatch:
  - Stimulus: START, 0xA2, 0x11, STOP.
  - Response: `sda_oe_o` stays 0 throughout, `addr_match_o` stays 0, `regs` unchanged.
- Pointer wrap:
  - Stimulus: write ptr 0x0F (DEPTH 16), data 0x11, 0x22.
  - Response: `regs[15]=0x11`, `regs[0]=0x22`, `wr_addr_o` sequence 15, 0.
- Aborted byte:
  - Stimulus: after the pointer, send 4 data bits, then STOP.
  - Response: no `wr_valid_o`, `ptr` unchanged, state IDLE, `busy_o`=0.
- Reset mid-ACK:
  - Stimulus: assert `reset_bit_n_i` low while `sda_oe_o`=1.
  - Response: `sda_oe_o`=0 immediately; all outputs at reset values; the next transaction ACKs normally.

Source files
------------

// File: rtl/i2c_slave_regfile_block_if.sv
// I2C bus pins as seen by the target.
//   scl_i    : bus SCL level (asynchronous to the core clock)
//   sda_i    : resolved bus SDA level (asynchronous to the core clock)
//   sda_oe_o : 1 = target pulls SDA low, 0 = released
interface i2c_slave_regfile_block_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe_o;

  modport master (output scl_i, output sda_i, input sda_oe_o);
  modport slave  (input scl_i, input sda_i, output sda_oe_o);
endinterface

// File: rtl/i2c_slave_regfile_block.sv
// I2C target with a byte-wide register file behind an auto-incrementing pointer.
// The bus is oversampled by the core clock. Clock stretching is not supported.
// Ports:
//   i2c_core_clock_i : core clock
//   reset_bit_n_i    : asynchronous active-low reset
//   bus              : SCL/SDA inputs and the SDA pull-down enable
//   busy_o           : high from START until STOP
//   addr_match_o     : high from the address ACK until STOP or the next START
//   wr_valid_o       : one-cycle pulse for each stored data byte
//   wr_addr_o        : register index of the stored byte
//   wr_data_o        : value of the stored byte
module i2c_slave_regfile_block #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     i2c_core_clock_i,
  input  logic                     reset_bit_n_i,
  i2c_slave_regfile_block_if.slave bus,
  output logic                     busy_o,
  output logic                     addr_match_o,
  output logic                     wr_valid_o,
  output logic [$clog2(DEPTH)-1:0] wr_addr_o,
  output logic [7:0]               wr_data_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  // Synchronizers plus one history flop; reset to the idle-bus level
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= bus.scl_i; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= bus.sda_i; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            rw_q, rw_d;
  logic            mack_q, mack_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            match_q, match_d;
  logic            wr_valid_q, wr_valid_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            reg_we;
  logic [7:0]      regs_q [DEPTH];
  logic [7:0]      byte_in;
  logic [7:0]      rd_byte;

  assign byte_in = {shift_q[6:0], sda_s2};
  assign rd_byte = regs_q[ptr_q];

  // Next-state and datapath decisions; START/STOP override everything
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    match_d    = match_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;

    if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      match_d   = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      match_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == S_ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state_d = S_ADDR_ACK;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = S_IDLE;
                end
              end else if (state_q == S_PTR) begin
                ptr_d   = byte_in[AW-1:0];
                state_d = S_PTR_ACK;
              end else begin
                reg_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + AW'(1);
                state_d    = S_WDATA_ACK;
              end
            end
          end
        end
        // sda_oe_q doubles as the phase flag: first fall drives ACK, second releases
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              if (state_q == S_ADDR_ACK) match_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_d   = S_RDATA;
                shift_d   = {rd_byte[6:0], 1'b0};
                sda_oe_d  = ~rd_byte[7];
                bit_cnt_d = 4'd1;
                ptr_d     = ptr_q + AW'(1);
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              mack_d    = 1'b0;
              state_d   = S_RDATA_ACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s2) state_d = S_IDLE;
            else        mack_d  = 1'b1;
          end else if (scl_fall && mack_q) begin
            state_d   = S_RDATA;
            shift_d   = {rd_byte[6:0], 1'b0};
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 4'd1;
            ptr_d     = ptr_q + AW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset releases SDA asynchronously
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      match_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      match_q    <= match_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register file
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else if (reg_we) begin
      regs_q[ptr_q] <= byte_in;
    end
  end

  assign bus.sda_oe_o = sda_oe_q;
  assign busy_o       = busy_q;
  assign addr_match_o = match_q;
  assign wr_valid_o   = wr_valid_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
endmodule
